serial_add_sequencer: RTL and testbench

Bit-serial add sequencer wrapped around the team's combinational full-adder stage (sum = a^b^c, carry = majority(a,b,c)). It captures two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock, LSB first, into the full adder with a registered carry. It collects the returned sum bits into a result register and reports completion with a one-cycle done pulse. The block sits directly upstream of the full adder, driving its inputs, and directly downstream of it, consuming its sum and carry outputs.

---
 rtl/serial_add_sequencer.sv | 126 ++++++++++++
 tb/tb_serial_add_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder front end: streams operand bits LSB-first into an external
// combinational full adder and gathers its sum bits into a registered result.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             load;
  logic             in_shift;
  logic             last_bit;
  logic [WIDTH-1:0] acc_next;

  // Start handshake: start is a request with no ready/ack; it is taken on any
  // rising edge where the block is in IDLE or DONE, and dropped otherwise.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    in_shift = (state_q == SHIFT);
    last_bit = (cnt == LAST_CNT);
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The full adder's sum bit lands at the top; the LSB of acc_next is only
  // ever needed as part of the final result.
  assign acc_next = {fa_s, acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (in_shift) begin
        acc   <= acc_next[WIDTH-1:1];
        carry <= fa_co;
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        // Hold on the final bit so the counter never wraps inside an operation.
        if (!last_bit) begin
          cnt <= cnt + 1'b1;
        end
        if (last_bit) begin
          sum_q  <= acc_next;
          cout_q <= fa_co;
        end
      end
    end
  end

  assign fa_a = in_shift & a_sh[0];
  assign fa_b = in_shift & b_sh[0];
  assign fa_c = in_shift & carry;
  assign busy = in_shift;
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and randomized bench for serial_add_sequencer with a behavioural
// full adder closing the loop on fa_* / fa_s / fa_co.
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_c;
  logic         fa_s;
  logic         fa_co;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[9];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_c  (fa_c),
    .fa_s  (fa_s),
    .fa_co (fa_co)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_fa_zero(input string nm);
    check({nm, "_fa"}, {29'd0, fa_a, fa_b, fa_c}, 32'd0);
  endtask

  // Runs one operation from IDLE/DONE, checking the bit stream every cycle.
  task automatic run_op(input vec_t v);
    logic c;
    logic [W-1:0] prev_sum;
    prev_sum = sum;
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    tick();
    start = 1'b0;
    c = v.cin;
    for (int i = 0; i < W; i++) begin
      check("busy", {31'd0, busy}, 32'd1);
      check("done_mid", {31'd0, done}, 32'd0);
      check("fa_a", {31'd0, fa_a}, {31'd0, v.a[i]});
      check("fa_b", {31'd0, fa_b}, {31'd0, v.b[i]});
      check("fa_c", {31'd0, fa_c}, {31'd0, c});
      check("sum_hold", {24'd0, sum}, {24'd0, prev_sum});
      c = (v.a[i] & v.b[i]) | (v.a[i] & c) | (v.b[i] & c);
      tick();
    end
    check("done", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("sum", {24'd0, sum}, {24'd0, v.s});
    check("cout", {31'd0, cout}, {31'd0, v.co});
    tick();
    check("done_after", {31'd0, done}, 32'd0);
    check("sum_after", {24'd0, sum}, {24'd0, v.s});
    check_fa_zero("idle");
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [W-1:0] held_s;
    logic         held_c;
    int           bad_hold;
    logic [W:0]   exp;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check_fa_zero("rst");
    rst = 1'b0;
    tick();

    // Table of directed vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i]);
    end

    // start in SHIFT is ignored: 0x12+0x34 with a stray start in cycle 3
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();                       // cycle 1
    start = 1'b0;
    tick();                       // cycle 2
    tick();                       // cycle 3
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();                       // cycle 4
    start = 1'b0;
    for (int k = 4; k < W + 1; k++) begin
      check("ign_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_sum", {24'd0, sum}, 32'h46);
    check("ign_cout", {31'd0, cout}, 32'd0);
    for (int k = 0; k < 2 * (W + 1); k++) begin
      tick();
      check("ign_no_done", {31'd0, done | busy}, 32'd0);
    end

    // Reset abort: 0x80+0x80, reset asserted in cycle 4
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();                       // cycle 4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check_fa_zero("abort");
    bad_hold = 0;
    for (int k = 0; k < 2 * (W + 1); k++) begin
      tick();
      if (done || busy || fa_a || fa_b || fa_c) bad_hold++;
    end
    check("abort_quiet", bad_hold, 32'd0);

    // start held high: 0x01+0x01+1 repeats every W+1 cycles
    a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
    tick();
    for (int k = 1; k <= 3 * (W + 1); k++) begin
      check("hold_done", {31'd0, done}, {31'd0, (k % (W + 1)) == 0});
      check("hold_busy", {31'd0, busy}, {31'd0, (k % (W + 1)) != 0});
      if ((k % (W + 1)) == 0) begin
        check("hold_sum", {24'd0, sum}, 32'h03);
        check("hold_cout", {31'd0, cout}, 32'd0);
      end
      if (k == 3 * (W + 1)) start = 1'b0;
      tick();
    end
    check("hold_stop", {31'd0, busy | done}, 32'd0);

    // Randomized operations with a result scoreboard and hold check
    held_s = sum;
    held_c = cout;
    for (int n = 0; n < 1000; n++) begin
      bad_hold = 0;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        if (sum !== held_s || cout !== held_c) bad_hold++;
        tick();
      end
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      exp_q.push_back(exp);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
        if (sum !== held_s || cout !== held_c || done) bad_hold++;
        tick();
      end
      check("rnd_hold", bad_hold, 32'd0);
      check("rnd_done", {31'd0, done}, 32'd1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("rnd_result", {23'd0, cout, sum}, {23'd0, exp});
      end
      held_s = sum;
      held_c = cout;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
